// File: rtl/index_stream_encoder.sv
// Index-stream encoder: emits the bit position of every set bit of a captured
// word over valid/ready, then a one-cycle done pulse with parity and count.
// Define MSB_FIRST_EN to emit indices in descending order (default ascending).
module index_stream_encoder #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic [IDX_W-1:0]  index_out,
  output logic              index_valid,
  input  logic              index_ready,
  output logic              done,
  output logic              parity_out,
  output logic [IDX_W:0]    count_out
);

  if (DATA_W < 2 || DATA_W > 32 || (DATA_W & (DATA_W - 1)) != 0 ||
      IDX_W != $clog2(DATA_W)) begin : g_bad_params
    $fatal(1, "index_stream_encoder: DATA_W must be a power of 2 in 2..32 and IDX_W == clog2(DATA_W)");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   shadow_q;
  logic [IDX_W-1:0]    index_q;
  logic                valid_q;
  logic                done_q;
  logic                parity_q;
  logic [IDX_W:0]      count_q;

  logic [DATA_W-1:0]   shadow_d;
  logic [IDX_W-1:0]    first_idx;
  logic [IDX_W-1:0]    next_idx;

  // Position of the bit to send first from a word; 0 for an all-zero word.
  function automatic logic [IDX_W-1:0] pick_index(input logic [DATA_W-1:0] w);
    logic [IDX_W-1:0] idx;
    idx = '0;
`ifdef MSB_FIRST_EN
    for (int i = 0; i < DATA_W; i++) begin
      if (w[i]) idx = IDX_W'(i);
    end
`else
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (w[i]) idx = IDX_W'(i);
    end
`endif
    return idx;
  endfunction

  // Shadow with the currently offered bit retired; used when the handshake fires.
  assign shadow_d  = shadow_q & ~(DATA_W'(1) << index_q);
  assign first_idx = pick_index(data_in);
  assign next_idx  = pick_index(shadow_d);

  // NOTE: every register below is updated with <= so all of them see the
  // values from before the edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      index_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      parity_q <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shadow_q <= data_in;
            parity_q <= 1'b0;
            count_q  <= '0;
            if (data_in == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SEND;
              valid_q <= 1'b1;
              index_q <= first_idx;
            end
          end
        end
        S_SEND: begin
          if (valid_q && index_ready) begin
            shadow_q <= shadow_d;
            parity_q <= ~parity_q;
            count_q  <= count_q + (IDX_W + 1)'(1);
            if (shadow_d == '0) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              index_q <= next_idx;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign index_out   = index_q;
  assign index_valid = valid_q;
  assign done        = done_q;
  assign parity_out  = parity_q;
  assign count_out   = count_q;

endmodule

// File: tb/tb_index_stream_encoder.sv
// Self-checking bench for index_stream_encoder: vector table, hand-written
// reset/backpressure sequences and random words decoded by a toggle-bit model.
module tb_index_stream_encoder;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;

  logic              clk;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic [IDX_W-1:0]  index_out;
  logic              index_valid;
  logic              index_ready;
  logic              done;
  logic              parity_out;
  logic [IDX_W:0]    count_out;

  int n_cmp  = 0;
  int n_fail = 0;

  index_stream_encoder #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .busy        (busy),
    .index_out   (index_out),
    .index_valid (index_valid),
    .index_ready (index_ready),
    .done        (done),
    .parity_out  (parity_out),
    .count_out   (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode: 0 = ready always high, 1 = ready low on cycles 1..3, 2 = random ready
  typedef struct {
    logic [DATA_W-1:0] data;
    int                mode;
    bit                poke;       // second start (data 0x01) on cycle 2
    int                exp_count;
    bit                exp_parity;
    int                exp_done;   // -1 = don't check latency
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ready_for(input int mode, input int k);
    if (mode == 1) return !(k >= 1 && k <= 3);
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  // Start one word and follow it to completion; a toggle-bit decoder rebuilds it.
  task automatic run_word(input vec_t v);
    int                exp_q[$];
    int                pos;
    int                k;
    bit                got_done;
    bit                rdy;
    bit                prev_valid;
    bit                prev_ready;
    logic [IDX_W-1:0]  prev_idx;
    logic [DATA_W-1:0] recon;

    exp_q.delete();
`ifdef MSB_FIRST_EN
    for (int i = DATA_W - 1; i >= 0; i--) if (v.data[i]) exp_q.push_back(i);
`else
    for (int i = 0; i < DATA_W; i++) if (v.data[i]) exp_q.push_back(i);
`endif
    pos = 0;
    recon = '0;
    got_done = 1'b0;
    prev_valid = 1'b0;
    prev_ready = 1'b1;
    prev_idx = '0;

    start = 1'b1;
    data_in = v.data;
    index_ready = 1'b1;
    @(negedge clk);
    k = 1;
    while (!got_done && k <= 100) begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 32'(index_valid), 32'd1);
        check("hold_index", 32'(index_out), 32'(prev_idx));
      end
      if (done) begin
        got_done = 1'b1;
        if (v.exp_done >= 0) check("done_cycle", k, v.exp_done);
        check("done_valid_low", 32'(index_valid), 32'd0);
        check("count_out", 32'(count_out), v.exp_count);
        check("parity_out", 32'(parity_out), 32'(v.exp_parity));
        check("n_indices", pos, exp_q.size());
        check("recon_word", 32'(recon), 32'(v.data));
        check("recon_parity", 32'(^recon), 32'(parity_out));
        start = 1'b0;
        @(negedge clk);
        check("done_pulse_1cyc", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
      end else begin
        if (index_valid) check("busy_in_send", 32'(busy), 32'd1);
        rdy = ready_for(v.mode, k);
        index_ready = rdy;
        if (v.poke && k == 2) begin
          start = 1'b1;
          data_in = 8'h01;
        end else begin
          start = 1'b0;
          data_in = DATA_W'($urandom);
        end
        if (index_valid && rdy) begin
          if (pos < exp_q.size()) check("index_out", 32'(index_out), exp_q[pos]);
          else check("extra_index", 32'(pos), 32'(exp_q.size()));
          recon[index_out] = ~recon[index_out];
          pos++;
        end
        prev_valid = index_valid;
        prev_ready = rdy;
        prev_idx = index_out;
        @(negedge clk);
        k++;
      end
    end
    if (!got_done) check("done_timeout", 32'd0, 32'd1);
    start = 1'b0;
    index_ready = 1'b1;
  endtask

  vec_t vecs[7];
  vec_t rv;

  initial begin
    vecs[0] = '{8'hA5, 0, 1'b0, 4, 1'b0, 5};
    vecs[1] = '{8'h00, 0, 1'b0, 0, 1'b0, 1};
    vecs[2] = '{8'h07, 1, 1'b0, 3, 1'b1, 7};
    vecs[3] = '{8'hFF, 0, 1'b1, 8, 1'b0, 9};
    vecs[4] = '{8'h01, 0, 1'b0, 1, 1'b1, 2};
    vecs[5] = '{8'h3C, 1, 1'b0, 4, 1'b0, 8};
    vecs[6] = '{8'h80, 0, 1'b0, 1, 1'b1, 2};

    rst = 1'b1;
    start = 1'b0;
    data_in = '0;
    index_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(index_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_parity", 32'(parity_out), 32'd0);
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_index", 32'(index_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_word(vecs[i]);

    // Reset in the middle of 0xF0 after two indices have been accepted.
    start = 1'b1;
    data_in = 8'hF0;
    index_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_count_pre_rst", 32'(count_out), 32'd2);
    check("mid_valid_pre_rst", 32'(index_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(index_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_count", 32'(count_out), 32'd0);
    @(negedge clk);
    check("mid_rst_no_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_word(vecs[6]);

    // Random words with random backpressure, checked against the toggle decoder.
    for (int n = 0; n < 20; n++) begin
      rv.data = DATA_W'($urandom);
      case ($urandom_range(0, 9))
        0: rv.data = '0;
        1: rv.data = '1;
        default: ;
      endcase
      rv.mode = 2;
      rv.poke = 1'b0;
      rv.exp_count = $countones(rv.data);
      rv.exp_parity = ^rv.data;
      rv.exp_done = -1;
      run_word(rv);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
